// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg
//   Shared definitions for the SPI master arbiter: FSM state encoding and
//   default timing parameters.
//   Optional watchdog macro: SPI_ARB_TIMEOUT_EN (see spi_arbiter.sv).
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TRIG = 3'd1,
    ST_BUSY = 3'd2,
    ST_DONE = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam int GAP_CYCLES_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 4096;
  localparam int TMO_CNT_W          = 16;
  localparam int GAP_CNT_W          = 8;

endpackage

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if
//   Bundles the requester-side and SPI-master-side signals of the arbiter.
//   slave  : arbiter view (drives grant/done/rsp_data/err and the master's
//            trig/data/reset, steers cs_n)
//   master : environment view (requesters plus the shared SPI master)
//   Requester side : req, req_data, grant, done, rsp_data, err
//   Master side    : spi_data_in, spi_trig, spi_done, spi_data_out, spi_cs,
//                    cs_n, spi_rst
interface spi_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      rsp_data;
  logic                  err;

  logic [WIDTH-1:0]      spi_data_in;
  logic                  spi_trig;
  logic                  spi_done;
  logic [WIDTH-1:0]      spi_data_out;
  logic                  spi_cs;
  logic [NREQ-1:0]       cs_n;
  logic                  spi_rst;

  modport slave (
    input  req, req_data, spi_done, spi_data_out, spi_cs,
    output grant, done, rsp_data, err, spi_data_in, spi_trig, cs_n, spi_rst
  );

  modport master (
    output req, req_data, spi_done, spi_data_out, spi_cs,
    input  grant, done, rsp_data, err, spi_data_in, spi_trig, cs_n, spi_rst
  );

endinterface

// File: rtl/spi_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin priority picker. Searches req upward starting
//   at rr_ptr, wrapping modulo NREQ, and returns the first set bit.
//   Ports:
//     req     in  NREQ   request vector
//     rr_ptr  in  PTR_W  index with highest priority this round
//     win_oh  out NREQ   one-hot winner (0 when no request)
//     win_idx out PTR_W  binary index of the winner
//     valid   out 1      at least one request is set
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  win_oh,
  output logic [PTR_W-1:0] win_idx,
  output logic             valid
);

  logic [PTR_W-1:0] sel;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    valid   = 1'b0;
    sel     = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Modulo keeps the search in range even for non power-of-two NREQ.
      sel = PTR_W'((int'(rr_ptr) + k) % NREQ);
      if (!valid && req[sel]) begin
        valid       = 1'b1;
        win_oh[sel] = 1'b1;
        win_idx     = sel;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter
//   Shares one SPI master (trig/done handshake) between NREQ requesters
//   with round-robin arbitration, per-requester chip-select steering and a
//   fixed CS-high gap between transactions.
//   Optional feature macro: SPI_ARB_TIMEOUT_EN -- BUSY watchdog that aborts
//   a transaction after TIMEOUT_CYCLES, pulsing err/spi_rst with done.
//   Ports:
//     CLK50MHZ  in   system clock, rising edge
//     RST       in   asynchronous active-high reset
//     bus       slave modport of spi_arbiter_if (requester and master sides)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for any request; picks a winner round-robin
//   TRIG    | spi_trig high for one cycle, owner word on spi_data_in
//   BUSY    | waiting for spi_done (or watchdog expiry when built)
//   DONE    | done[owner] pulse, rsp_data valid, rr_ptr advances
//   GAP     | CS-high gap of GAP_CYCLES; requests are not sampled
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int NREQ           = 2,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic          CLK50MHZ,
  input  logic          RST,
  spi_arbiter_if.slave  bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);

  state_t                 state_q,    state_d;
  logic [PTR_W-1:0]       rr_ptr_q,   rr_ptr_d;
  logic [PTR_W-1:0]       owner_q,    owner_d;
  logic [NREQ-1:0]        grant_q,    grant_d;
  logic [NREQ-1:0]        done_q,     done_d;
  logic [WIDTH-1:0]       rsp_data_q, rsp_data_d;
  logic                   spi_trig_q, spi_trig_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q,  gap_cnt_d;

  logic [NREQ-1:0]        pick_oh;
  logic [PTR_W-1:0]       pick_idx;
  logic                   pick_valid;

  logic                   data_phase;
  logic [WIDTH-1:0]       spi_data_in_c;
  logic [NREQ-1:0]        cs_n_c;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_CNT_W-1:0]   tmo_cnt_q,  tmo_cnt_d;
  logic                   err_q,      err_d;
  logic                   spi_rst_q,  spi_rst_d;
`else
  // Watchdog limit has no hardware behind it in this build.
  if (TIMEOUT_CYCLES > 0) begin : g_no_watchdog
  end
`endif

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    done_d     = '0;
    rsp_data_d = rsp_data_q;
    spi_trig_d = 1'b0;
    gap_cnt_d  = gap_cnt_q;
`ifdef SPI_ARB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    err_d      = 1'b0;
    spi_rst_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d    = pick_idx;
          grant_d    = pick_oh;
          spi_trig_d = 1'b1;
          state_d    = ST_TRIG;
        end
      end
      ST_TRIG: begin
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        // grant_q is the one-hot form of owner_q, so it doubles as done[owner].
        if (bus.spi_done) begin
          rsp_data_d = bus.spi_data_out;
          done_d     = grant_q;
          state_d    = ST_DONE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LIMIT) begin
          rsp_data_d = '0;
          done_d     = grant_q;
          err_d      = 1'b1;
          spi_rst_d  = 1'b1;
          state_d    = ST_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        rr_ptr_d  = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
        grant_d   = '0;
        gap_cnt_d = GAP_LOAD;
        state_d   = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      rsp_data_q <= '0;
      spi_trig_q <= 1'b0;
      gap_cnt_q  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      err_q      <= 1'b0;
      spi_rst_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      rsp_data_q <= rsp_data_d;
      spi_trig_q <= spi_trig_d;
      gap_cnt_q  <= gap_cnt_d;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      err_q      <= err_d;
      spi_rst_q  <= spi_rst_d;
`endif
    end
  end

  assign data_phase = (state_q == ST_TRIG) || (state_q == ST_BUSY) ||
                      (state_q == ST_DONE);

  always_comb begin
    spi_data_in_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (data_phase && (owner_q == PTR_W'(i))) begin
        spi_data_in_c = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Combinational so the steered CS edges line up with the master's SCK.
  always_comb begin
    cs_n_c = '1;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        cs_n_c[i] = bus.spi_cs;
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.spi_trig    = spi_trig_q;
  assign bus.spi_data_in = spi_data_in_c;
  assign bus.cs_n        = cs_n_c;

`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.err     = err_q;
  assign bus.spi_rst = spi_rst_q;
`else
  assign bus.err     = 1'b0;
  assign bus.spi_rst = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter
//   Scoreboard bench for spi_arbiter: expected completions are queued when a
//   request is launched and compared when done pulses. A behavioural SPI
//   master returns (word sent) ^ miso_key after SHIFT cycles.
module tb_spi_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 2;
  localparam int GAP   = 4;
  localparam int TMO   = 64;
  localparam int SHIFT = 8;

  typedef struct {
    logic [NREQ-1:0]  oh;
    logic [WIDTH-1:0] rsp;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  spi_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  spi_arbiter #(
    .WIDTH          (WIDTH),
    .NREQ           (NREQ),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK50MHZ (clk),
    .RST      (rst),
    .bus      (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp_t sb_q[$];
  exp_t e;
  int   n_done        = 0;
  int   trig_count    = 0;
  int   last_trig_cyc = 0;
  int   last_done_cyc = 0;
  int   last_spacing  = 0;
  int   exp_trigs     = 0;

  logic [WIDTH-1:0] miso_key;
  logic             master_mute;
  logic             m_done, m_cs, m_busy, spur_done;
  logic [WIDTH-1:0] m_dout, m_word;
  int               m_cnt;
  int               m_done_cyc = 0;

  assign bus.spi_done     = m_done | spur_done;
  assign bus.spi_cs       = m_cs;
  assign bus.spi_data_out = m_dout;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [NREQ-1:0] oh, input logic [WIDTH-1:0] rsp, input logic err);
    exp_t x;
    x.oh  = oh;
    x.rsp = rsp;
    x.err = err;
    sb_q.push_back(x);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && n_done < target; i++) begin
      @(negedge clk); #1;
    end
    chk("wait_done_reached", 64'(n_done >= target), 64'd1);
  endtask

  task automatic wait_trig(input int target);
    for (int i = 0; i < 400 && trig_count < target; i++) begin
      @(negedge clk); #1;
    end
    chk("wait_trig_reached", 64'(trig_count >= target), 64'd1);
  endtask

  // Behavioural SPI master.
  initial begin
    m_done = 1'b0; m_cs = 1'b1; m_dout = '0; m_busy = 1'b0; m_cnt = 0; m_word = '0;
    forever begin
      @(posedge clk); #1;
      m_done = 1'b0;
      if (rst || bus.spi_rst) begin
        m_busy = 1'b0;
        m_cs   = 1'b1;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_dout     = m_word ^ miso_key;
          m_done     = 1'b1;
          m_cs       = 1'b1;
          m_busy     = 1'b0;
          m_done_cyc = cyc;
        end else begin
          m_cnt--;
        end
      end else if (bus.spi_trig) begin
        m_word = bus.spi_data_in;
        m_cs   = 1'b0;
        m_busy = 1'b1;
        m_cnt  = master_mute ? 1000000 : SHIFT;
      end
    end
  end

  // Scoreboard consumer and trig monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.spi_trig) begin
          trig_count++;
          last_spacing  = cyc - last_done_cyc;
          last_trig_cyc = cyc;
        end
        if (bus.done != '0) begin
          n_done++;
          last_done_cyc = cyc;
          if (sb_q.size() == 0) begin
            chk("done_unexpected", 64'(bus.done), 64'd0);
          end else begin
            e = sb_q.pop_front();
            chk("done_owner", 64'(bus.done), 64'(e.oh));
            chk("grant_at_done", 64'(bus.grant), 64'(e.oh));
            chk("rsp_data", 64'(bus.rsp_data), 64'(e.rsp));
            chk("err_at_done", 64'(bus.err), 64'(e.err));
            chk("spi_rst_at_done", 64'(bus.spi_rst), 64'(e.err));
            if (e.err) chk("busy_len", 64'(cyc - last_trig_cyc), 64'(TMO + 1));
            else       chk("done_latency", 64'(cyc - m_done_cyc), 64'd1);
          end
        end
      end
    end
  end

  initial begin
    #(20 * 40000);
    $display("FAIL global_timeout: got=stuck expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] d0, d1;
    bus.req = '0; bus.req_data = '0; spur_done = 1'b0;
    miso_key = '0; master_mute = 1'b0;

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant",    64'(bus.grant), 64'd0);
    chk("rst_done",     64'(bus.done), 64'd0);
    chk("rst_rsp",      64'(bus.rsp_data), 64'd0);
    chk("rst_err",      64'(bus.err), 64'd0);
    chk("rst_trig",     64'(bus.spi_trig), 64'd0);
    chk("rst_spi_rst",  64'(bus.spi_rst), 64'd0);
    chk("rst_cs_n",     64'(bus.cs_n), 64'h3);
    chk("rst_data_in",  64'(bus.spi_data_in), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Contention: both held, owners alternate 0,1,0,1
    d0 = 32'h1111_AAAA; d1 = 32'h2222_BBBB;
    bus.req_data = {d1, d0};
    miso_key = 32'h0F0F_F0F0;
    push_exp(2'b01, d0 ^ miso_key, 1'b0);
    push_exp(2'b10, d1 ^ miso_key, 1'b0);
    push_exp(2'b01, d0 ^ miso_key, 1'b0);
    push_exp(2'b10, d1 ^ miso_key, 1'b0);
    bus.req = 2'b11;
    exp_trigs += 4;
    for (int k = 1; k <= 4; k++) begin
      wait_done(k);
      if (k == 4) begin
        bus.req = '0;
      end else begin
        wait_trig(k + 1);
        chk("gap_spacing", 64'(last_spacing), 64'(GAP + 2));
      end
    end
    repeat (10) @(posedge clk);

    // Single request from requester 0
    d0 = 32'hA5A5_0F0F; d1 = 32'hDEAD_BEEF;
    bus.req_data = {d1, d0};
    miso_key = 32'hA5A5_0F0F ^ 32'h1234_5678;
    @(posedge clk); #1;
    push_exp(2'b01, 32'h1234_5678, 1'b0);
    bus.req = 2'b01;
    exp_trigs += 1;
    chk("single_trig_pre", 64'(bus.spi_trig), 64'd0);
    @(posedge clk); #1;
    chk("single_trig", 64'(bus.spi_trig), 64'd1);
    chk("single_grant", 64'(bus.grant), 64'h1);
    chk("single_data_in", 64'(bus.spi_data_in), 64'hA5A5_0F0F);
    @(posedge clk); #1;
    chk("single_trig_width", 64'(bus.spi_trig), 64'd0);
    @(negedge clk);
    chk("cs_n_steer_busy", 64'(bus.cs_n), 64'h2);
    wait_done(5);
    bus.req = '0;
    for (int i = 0; i < GAP; i++) begin
      @(negedge clk);
      chk("gap_grant", 64'(bus.grant), 64'd0);
      chk("gap_cs_n", 64'(bus.cs_n), 64'h3);
    end
    repeat (6) @(posedge clk);

    // Request drop: req[1] released during BUSY, transaction still completes
    @(posedge clk); #1;
    push_exp(2'b10, d1 ^ miso_key, 1'b0);
    bus.req = 2'b10;
    exp_trigs += 1;
    wait_trig(exp_trigs);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req = '0;
    wait_done(6);
    repeat (20) @(negedge clk);
    chk("no_retrigger", 64'(trig_count), 64'(exp_trigs));
    chk("drop_done_count", 64'(n_done), 64'd6);

    // Spurious spi_done in IDLE
    @(posedge clk); #1;
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (6) @(negedge clk);
    chk("spur_grant", 64'(bus.grant), 64'd0);
    chk("spur_trig_count", 64'(trig_count), 64'(exp_trigs));
    chk("spur_rsp_held", 64'(bus.rsp_data), 64'(d1 ^ miso_key));
    chk("spur_done_count", 64'(n_done), 64'd6);

    // Reset mid-BUSY: first make rr_ptr point at requester 1
    @(posedge clk); #1;
    push_exp(2'b01, d0 ^ miso_key, 1'b0);
    bus.req = 2'b01;
    exp_trigs += 1;
    wait_done(7);
    bus.req = '0;
    repeat (GAP + 3) @(posedge clk);
    #1;
    bus.req = 2'b10;
    exp_trigs += 1;
    wait_trig(exp_trigs);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_grant", 64'(bus.grant), 64'h2);
    chk("pre_rst_cs_n", 64'(bus.cs_n), 64'h1);
    #5;
    rst = 1'b1;
    #1;
    chk("mid_rst_grant", 64'(bus.grant), 64'd0);
    chk("mid_rst_cs_n", 64'(bus.cs_n), 64'h3);
    chk("mid_rst_trig", 64'(bus.spi_trig), 64'd0);
    chk("mid_rst_rsp", 64'(bus.rsp_data), 64'd0);
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push_exp(2'b01, d0 ^ miso_key, 1'b0);
    push_exp(2'b10, d1 ^ miso_key, 1'b0);
    bus.req = 2'b11;
    exp_trigs += 2;
    wait_done(8);
    wait_done(9);
    bus.req = '0;
    repeat (GAP + 4) @(posedge clk);
    chk("post_rst_trig_count", 64'(trig_count), 64'(exp_trigs));

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog: master never answers
    master_mute = 1'b1;
    @(posedge clk); #1;
    push_exp(2'b01, '0, 1'b1);
    bus.req = 2'b01;
    exp_trigs += 1;
    wait_done(10);
    master_mute = 1'b0;
    push_exp(2'b10, d1 ^ miso_key, 1'b0);
    bus.req = 2'b10;
    exp_trigs += 1;
    wait_trig(exp_trigs);
    chk("tmo_next_spacing", 64'(last_spacing), 64'(GAP + 2));
    wait_done(11);
    bus.req = '0;
    repeat (GAP + 4) @(posedge clk);
`endif

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares one `spi` master (32-bit shift, trig/done handshake) between NREQ requesters, e.g. the DAC and the preamp/ADC blocks on the Spartan-3 board.
- Uses round-robin arbitration. Sequences `spi_trig` and waits for `spi_done`, then returns the received word to the winner.
- Steers the master's single chip-select to a per-requester CS line.
- Enforces a minimum CS-high gap between transactions.

Parameters:
- WIDTH, 32, SPI word width; must match the `spi` master's WIDTH.
- NREQ, 2, number of requesters; range 2..8.
- GAP_CYCLES, 4, CLK50MHZ cycles spent in GAP after each transaction; range 1..255.
- TIMEOUT_CYCLES, 4096, watchdog limit; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- CLK50MHZ  in  1  system clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; level, held until the matching done pulse.
- req_data  in  NREQ*WIDTH  concatenated TX words; requester i uses bits [i*WIDTH +: WIDTH].
- grant  out  NREQ  one-hot owner; asserted from TRIG through DONE.
- done  out  NREQ  one-cycle completion pulse to the owner.
- rsp_data  out  WIDTH  RX word of the last completed transaction.
- err  out  1  one-cycle pulse on watchdog abort; tied 0 without the optional feature.
- spi_data_in  out  WIDTH  word to the master.
- spi_trig  out  1  one-cycle start pulse to the master.
- spi_done  in  1  master completion pulse.
- spi_data_out  in  WIDTH  master RX shift register.
- spi_cs  in  1  master chip-select, active low.
- cs_n  out  NREQ  steered per-device chip-selects, active low.
- spi_rst  out  1  master reset request; pulses on watchdog abort only.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, grant=0, done=0, rsp_data=0, err=0, spi_trig=0, spi_rst=0. cs_n is all ones.
- States: IDLE -> TRIG -> BUSY -> DONE -> GAP -> IDLE.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Register the winner as owner, set grant one-hot, and go to TRIG.
  - Winner-to-TRIG latency is 1 cycle.
- TRIG:
  - spi_trig=1 for exactly this one cycle.
  - spi_data_in = req_data slice of the owner. It is driven from the owner register in TRIG, BUSY and DONE, and is 0 otherwise.
  - Next state is BUSY.
- BUSY:
  - Wait for spi_done.
  - On spi_done, capture spi_data_out into rsp_data and go to DONE.
- DONE:
  - done[owner]=1 for one cycle, and rsp_data is valid in this cycle.
  - rr_ptr = (owner+1) mod NREQ.
  - Next state is GAP.
- GAP:
  - grant=0.
  - Count GAP_CYCLES, then go to IDLE.
  - Requests are not sampled during GAP.
- cs_n steering: cs_n[i] = spi_cs when grant[i], else 1. This is combinational so it stays aligned with the master's SCK.
- req deasserted mid-transaction: ignored; the transaction completes and done still pulses.
- req_data changing during BUSY: not permitted, since the master loads only while waiting.
- Simultaneous requests: round-robin order applies. With NREQ=2 and both held continuously, owners alternate 0,1,0,1.
- spi_done outside BUSY: ignored.
- RST asserted mid-transaction: immediately returns to the reset values. The master shares RST.

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on entry to BUSY and increments in BUSY.
  - When it reaches TIMEOUT_CYCLES without spi_done, err and spi_rst pulse for one cycle.
  - done[owner] pulses in the same cycle, and rsp_data is forced to 0.
  - The block then goes to GAP and rr_ptr still advances.
- Without the macro: no counter is built, err=0 and spi_rst=0 constantly, and BUSY waits indefinitely.

Decomposition:
- Package spi_arb_pkg holds:
  - state encoding constants ST_IDLE, ST_TRIG, ST_BUSY, ST_DONE, ST_GAP (3-bit);
  - the default GAP_CYCLES and TIMEOUT_CYCLES values.
- One sub-module, rr_pick: combinational round-robin priority picker. It takes req and rr_ptr and returns a one-hot winner plus a valid flag, which makes it reusable by later arbiters.

Test Plan:
- Single request: req=2'b01, req_data[31:0]=32'hA5A5_0F0F, behavioural master echoing MISO=32'h1234_5678.
  - Required: spi_trig one cycle after req is sampled, and cs_n[0] follows spi_cs while cs_n[1] stays 1.
  - Required: done=2'b01 one cycle after spi_done, rsp_data=32'h1234_5678, then GAP for 4 cycles.
- Contention: req=2'b11 held for 4 transactions. Required: grant sequence 01,10,01,10 and four done pulses alternating between requesters.
- Request drop: req[1] released during BUSY. Required: the transaction completes, done[1] still pulses, and no retrigger occurs.
- Reset mid-BUSY: RST asserted asynchronously between clock edges. Required: grant=0, cs_n=2'b11 and spi_trig=0 immediately; after release the block is in IDLE with rr_ptr=0.
- Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64): master never returns spi_done.
  - Required: after 64 BUSY cycles, err, spi_rst and done[owner] pulse together and rsp_data=0.
  - Required: the next request is served after GAP.
- Spurious spi_done asserted in IDLE: no done pulse and no state change.
